// File: rtl/lcd_text_buffer.sv
// 32-entry character frame buffer with a valid/ready command port and a zero-latency combinational read port.
// Writes are visible just after the accept edge; CLEAR sweeps one entry per cycle and holds oWR_READY low for 33 clocks.
module lcd_text_buffer #(
    parameter logic [7:0] FILL_CHAR = 8'h20,
    parameter int         DEPTH     = 32
) (
    input  logic       iCLK_50MHZ,
    input  logic       iRST_N,
    input  logic       iWR_VALID,
    output logic       oWR_READY,
    input  logic [1:0] iWR_CMD,
    input  logic [7:0] iWR_DATA,
    input  logic [4:0] index,
    output logic [7:0] out,
    output logic [4:0] oCURSOR,
    output logic       oBUSY,
    output logic       oDIRTY,
    input  logic       iDIRTY_CLR
);

    typedef enum logic [1:0] {
        CMD_WRCHAR = 2'b00,
        CMD_SETCUR = 2'b01,
        CMD_CLEAR  = 2'b10,
        CMD_WRHEX  = 2'b11
    } cmd_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic [4:0] LAST_IDX = 5'(DEPTH - 1);

    state_e     state_q;
    logic [4:0] cursor_q;
    logic [4:0] sweep_q;
    logic       ready_q;
    logic       dirty_q;
    logic [7:0] mem_q [DEPTH];

    logic       accept;
    logic       wr_en_d;
    logic [4:0] wr_addr_d;
    logic [7:0] wr_byte_d;
    logic [3:0] nib;
    logic [7:0] hex_d;
    logic       dirty_set;

    assign accept = iWR_VALID && ready_q;

    always_comb begin
        nib       = iWR_DATA[3:0];
        hex_d     = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        wr_en_d   = 1'b0;
        wr_addr_d = cursor_q;
        wr_byte_d = iWR_DATA;
        dirty_set = 1'b0;
        if (state_q == ST_CLEAR) begin
            wr_en_d   = 1'b1;
            wr_addr_d = sweep_q;
            wr_byte_d = FILL_CHAR;
            dirty_set = (sweep_q == LAST_IDX);
        end else if (accept && (iWR_CMD == CMD_WRCHAR)) begin
            wr_en_d   = 1'b1;
            dirty_set = 1'b1;
        end else if (accept && (iWR_CMD == CMD_WRHEX)) begin
            wr_en_d   = 1'b1;
            wr_byte_d = hex_d;
            dirty_set = 1'b1;
        end
    end

    // Storage resets to FILL_CHAR so an abort mid-sweep still leaves a blank display.
    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= FILL_CHAR;
            end
        end else if (wr_en_d) begin
            mem_q[wr_addr_d] <= wr_byte_d;
        end
    end

    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= ST_IDLE;
            cursor_q <= 5'd0;
            sweep_q  <= 5'd0;
            ready_q  <= 1'b1;
            dirty_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        case (cmd_e'(iWR_CMD))
                            CMD_WRCHAR,
                            CMD_WRHEX:  cursor_q <= cursor_q + 5'd1;
                            CMD_SETCUR: cursor_q <= iWR_DATA[4:0];
                            CMD_CLEAR: begin
                                state_q <= ST_CLEAR;
                                sweep_q <= 5'd0;
                                ready_q <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CLEAR: begin
                    // Ready stays low for one extra cycle after the sweep ends.
                    ready_q <= 1'b0;
                    sweep_q <= sweep_q + 5'd1;
                    if (sweep_q == LAST_IDX) begin
                        cursor_q <= 5'd0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (dirty_set) begin
                dirty_q <= 1'b1;
            end else if (iDIRTY_CLR) begin
                dirty_q <= 1'b0;
            end
        end
    end

    assign out       = mem_q[index];
    assign oWR_READY = ready_q;
    assign oCURSOR   = cursor_q;
    assign oBUSY     = (state_q == ST_CLEAR);
    assign oDIRTY    = dirty_q;

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Self-checking bench for lcd_text_buffer: command table, scoreboarded full-buffer reads, clear-sweep and reset corner cases.
module tb_lcd_text_buffer;

    localparam logic [1:0] WRCHAR = 2'b00;
    localparam logic [1:0] SETCUR = 2'b01;
    localparam logic [1:0] CLEAR  = 2'b10;
    localparam logic [1:0] WRHEX  = 2'b11;
    localparam logic [7:0] SPACE  = 8'h20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [1:0] wr_cmd = 2'b00;
    logic [7:0] wr_data = 8'h00;
    logic [4:0] index = 5'd0;
    logic [7:0] rd_char;
    logic [4:0] cursor;
    logic       busy;
    logic       dirty;
    logic       dirty_clr = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_mem [32];
    logic [4:0] m_cur;
    logic [7:0] sb_q [$];

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] data;
        logic       dclr;
        logic [4:0] exp_cur;
        logic [4:0] idx;
        logic [7:0] exp_ch;
        logic       exp_dirty;
    } vec_t;

    vec_t tbl [12];

    always #10 clk = ~clk;

    lcd_text_buffer dut (
        .iCLK_50MHZ (clk),
        .iRST_N     (rst_n),
        .iWR_VALID  (wr_valid),
        .oWR_READY  (wr_ready),
        .iWR_CMD    (wr_cmd),
        .iWR_DATA   (wr_data),
        .index      (index),
        .out        (rd_char),
        .oCURSOR    (cursor),
        .oBUSY      (busy),
        .oDIRTY     (dirty),
        .iDIRTY_CLR (dirty_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = SPACE;
        m_cur = 5'd0;
    endtask

    task automatic model_apply(input logic [1:0] cmd, input logic [7:0] data);
        logic [3:0] n;
        n = data[3:0];
        case (cmd)
            WRCHAR: begin m_mem[m_cur] = data; m_cur = m_cur + 5'd1; end
            SETCUR: m_cur = data[4:0];
            WRHEX: begin
                m_mem[m_cur] = (n < 4'd10) ? ("0" + {4'h0, n}) : ("A" + {4'h0, n} - 8'd10);
                m_cur = m_cur + 5'd1;
            end
            default: model_reset();
        endcase
    endtask

    // Returns just after the accept edge with valid still asserted.
    task automatic send(input logic [1:0] cmd, input logic [7:0] data, input logic dclr);
        int n;
        n = 0;
        @(negedge clk);
        wr_valid  = 1'b1;
        wr_cmd    = cmd;
        wr_data   = data;
        dirty_clr = dclr;
        while (!wr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            $display("FAIL send_timeout: ready never rose for cmd %0h", cmd);
        end
        @(posedge clk);
        model_apply(cmd, data);
        #1 dirty_clr = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [7:0] exp;
        for (int i = 0; i < 32; i++) begin
            index = i[4:0];
            sb_q.push_back(m_mem[i]);
            #1;
            exp = sb_q.pop_front();
            chk($sformatf("%s_mem%0d", tag, i), rd_char, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{WRCHAR, 8'h41, 1'b0, 5'd1,  5'd0,  8'h41, 1'b1};
        tbl[1]  = '{WRCHAR, 8'h42, 1'b0, 5'd2,  5'd1,  8'h42, 1'b1};
        tbl[2]  = '{SETCUR, 8'hFF, 1'b1, 5'd31, 5'd31, 8'h20, 1'b0};
        tbl[3]  = '{WRHEX,  8'h0C, 1'b0, 5'd0,  5'd31, 8'h43, 1'b1};
        tbl[4]  = '{WRHEX,  8'h07, 1'b0, 5'd1,  5'd0,  8'h37, 1'b1};
        tbl[5]  = '{WRHEX,  8'hF5, 1'b0, 5'd2,  5'd1,  8'h35, 1'b1};
        tbl[6]  = '{WRHEX,  8'h0A, 1'b0, 5'd3,  5'd2,  8'h41, 1'b1};
        tbl[7]  = '{WRHEX,  8'h09, 1'b0, 5'd4,  5'd3,  8'h39, 1'b1};
        tbl[8]  = '{WRHEX,  8'h0F, 1'b0, 5'd5,  5'd4,  8'h46, 1'b1};
        tbl[9]  = '{SETCUR, 8'hE3, 1'b1, 5'd3,  5'd3,  8'h39, 1'b0};
        tbl[10] = '{WRCHAR, 8'h05, 1'b0, 5'd4,  5'd3,  8'h05, 1'b1};
        tbl[11] = '{WRCHAR, 8'hFE, 1'b1, 5'd5,  5'd4,  8'hFE, 1'b1};

        model_reset();
        repeat (3) @(negedge clk);
        chk("in_reset_out", {24'h0, rd_char}, 32'h20);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", wr_ready, 1);
        chk("rst_cursor", cursor, 0);
        chk("rst_dirty", dirty, 0);
        chk("rst_busy", busy, 0);
        check_all("rst");

        for (int r = 0; r < 12; r++) begin
            send(tbl[r].cmd, tbl[r].data, tbl[r].dclr);
            index = tbl[r].idx;
            #1;
            chk($sformatf("vec%0d_cursor", r), cursor, tbl[r].exp_cur);
            chk($sformatf("vec%0d_char", r), rd_char, tbl[r].exp_ch);
            chk($sformatf("vec%0d_dirty", r), dirty, tbl[r].exp_dirty);
        end
        idle();
        dirty_clr = 1'b1;
        @(posedge clk);
        #1 dirty_clr = 1'b0;
        chk("dirty_clr_pulse", dirty, 0);
        check_all("tbl");

        // Fill every entry, then CLEAR with a WRCHAR held pending behind it.
        send(SETCUR, 8'h00, 1'b0);
        for (int i = 0; i < 32; i++) send(WRCHAR, 8'h40 + i[7:0], 1'b0);
        send(CLEAR, 8'h00, 1'b0);
        begin
            int s;
            int busys;
            s = 0;
            busys = 0;
            @(negedge clk);
            wr_cmd  = WRCHAR;
            wr_data = 8'h5A;
            index   = 5'd10;
            while (!wr_ready && s < 100) begin
                if (busy) busys++;
                if (s == 10) chk("sweep_pending_e10", rd_char, 8'h4A);
                if (s == 11) chk("sweep_cleared_e10", rd_char, SPACE);
                s++;
                @(negedge clk);
            end
            chk("clear_ready_low_cycles", s, 33);
            chk("clear_busy_cycles", busys, 32);
        end
        @(posedge clk);
        model_apply(WRCHAR, 8'h5A);
        idle();
        chk("post_clear_cursor", cursor, 1);
        chk("post_clear_dirty", dirty, 1);
        check_all("clr");

        // Reset lands while the sweep is at entry 10.
        send(SETCUR, 8'd20, 1'b0);
        send(WRCHAR, 8'h55, 1'b0);
        send(CLEAR, 8'h00, 1'b0);
        idle();
        index = 5'd20;
        repeat (10) @(negedge clk);
        chk("midclr_busy", busy, 1);
        chk("midclr_e20_pending", rd_char, 8'h55);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_e20", rd_char, SPACE);
        chk("midrst_ready", wr_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_cursor", cursor, 0);
        chk("midrst_dirty", dirty, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", wr_ready, 1);
        check_all("midrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
